ram_loader: RTL

//   Bus-mastering program loader for the 8-bit breadboard CPU. On request it holds the CPU,

---
 rtl/ram_loader.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/ram_loader.sv
// Bus-mastering program loader: holds the CPU, writes a host byte stream into program RAM
// through MI/RI bus cycles, then releases the CPU with a one-cycle register clear.
module ram_loader #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NBYTES = 16
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              cpu_idle,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              cpu_hold,
  output logic              cpu_reset,
  output logic              bus_oe,
  output logic [DATA_W-1:0] bus_out,
  output logic              mi,
  output logic              ri,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [ADDR_W:0]   byte_count
);

  typedef enum logic [2:0] {
    StIdle,
    StGrant,
    StAddr,
    StWdata,
    StWrite,
    StRel,
    StAbrt
  } state_e;

  localparam logic [ADDR_W:0] LastCount = (ADDR_W + 1)'(NBYTES);

  state_e              r_state, w_state_d;
  logic [ADDR_W-1:0]   r_addr, w_addr_d;
  logic [DATA_W-1:0]   r_data, w_data_d;
  logic [ADDR_W:0]     r_count, w_count_d;
  logic [ADDR_W:0]     w_count_inc;
  logic [DATA_W-1:0]   w_addr_ext;

  assign w_count_inc = r_count + 1'b1;

  always_ff @(posedge clk) begin
    if (!clr) begin
      r_state <= StIdle;
      r_addr  <= '0;
      r_data  <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_d;
      r_addr  <= w_addr_d;
      r_data  <= w_data_d;
      r_count <= w_count_d;
    end
  end

  // Abort is taken from any bus-owning state; the strobe of the current cycle still lands.
  always_comb begin
    w_state_d = r_state;
    w_addr_d  = r_addr;
    w_data_d  = r_data;
    w_count_d = r_count;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_state_d = StGrant;
          w_addr_d  = base_addr;
          w_count_d = '0;
        end
      end
      StGrant: begin
        if (abort)         w_state_d = StAbrt;
        else if (cpu_idle) w_state_d = StAddr;
      end
      StAddr: begin
        w_state_d = abort ? StAbrt : StWdata;
      end
      StWdata: begin
        if (abort) begin
          w_state_d = StAbrt;
        end else if (in_valid) begin
          w_data_d  = in_data;
          w_state_d = StWrite;
        end
      end
      StWrite: begin
        w_count_d = w_count_inc;
        if (abort) begin
          w_state_d = StAbrt;
        end else if (w_count_inc == LastCount) begin
          w_state_d = StRel;
        end else begin
          w_addr_d  = r_addr + 1'b1;
          w_state_d = StAddr;
        end
      end
      StRel:   w_state_d = StIdle;
      StAbrt:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Moore outputs: decoded purely from registered state.
  always_comb begin
    w_addr_ext                = '0;
    w_addr_ext[ADDR_W-1:0]    = r_addr;
    in_ready   = 1'b0;
    cpu_hold   = 1'b0;
    cpu_reset  = 1'b0;
    bus_oe     = 1'b0;
    bus_out    = '0;
    mi         = 1'b0;
    ri         = 1'b0;
    done       = 1'b0;
    aborted    = 1'b0;
    busy       = (r_state != StIdle);
    byte_count = r_count;
    unique case (r_state)
      StIdle:  ;
      StGrant: cpu_hold = 1'b1;
      StAddr: begin
        cpu_hold = 1'b1;
        bus_oe   = 1'b1;
        mi       = 1'b1;
        bus_out  = w_addr_ext;
      end
      StWdata: begin
        cpu_hold = 1'b1;
        in_ready = 1'b1;
      end
      StWrite: begin
        cpu_hold = 1'b1;
        bus_oe   = 1'b1;
        ri       = 1'b1;
        bus_out  = r_data;
      end
      StRel: begin
        cpu_hold  = 1'b1;
        cpu_reset = 1'b1;
        done      = 1'b1;
      end
      StAbrt: begin
        cpu_hold = 1'b1;
        aborted  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
